// File: rtl/pp_column_shift_loader_pkg.sv
// Shared column geometry helpers and FSM state type for the
// partial-product column loader.
package pp_cols_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Height of weight column i in an n x n partial-product array.
    function automatic int unsigned col_height(input int unsigned i, input int unsigned n);
        int unsigned a;
        int unsigned b;
        a = i + 1;
        b = 2 * n - 1 - i;
        return (a < b) ? a : b;
    endfunction

    // Bit offset of column i inside the packed column vector.
    function automatic int unsigned col_offset(input int unsigned i, input int unsigned n);
        int unsigned s;
        s = 0;
        for (int unsigned k = 0; k < i; k++) begin
            s += col_height(k, n);
        end
        return s;
    endfunction

    // Total number of column bits; the column heights sum to n*n.
    function automatic int unsigned total_bits(input int unsigned n);
        return n * n;
    endfunction

endpackage

// File: rtl/pp_column_shift_loader_sreg.sv
// One weight column: an H-bit shift register, newest bit at the LSB,
// with synchronous clear and shift enable.
module pp_column_sreg #(
    parameter int unsigned H = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_shift,
    input  logic         i_clear,
    input  logic         i_bit,
    output logic [H-1:0] o_col
);

    logic [H-1:0] r_col;
    logic [H-1:0] w_shifted;

    // A height-1 column is simply replaced by the incoming bit.
    generate
        if (H == 1) begin : g_single
            assign w_shifted = i_bit;
        end else begin : g_multi
            assign w_shifted = {r_col[H-2:0], i_bit};
        end
    endgenerate

    // Column storage: clear wins over shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
        end else if (i_clear) begin
            r_col <= '0;
        end else if (i_shift) begin
            r_col <= w_shifted;
        end
    end

    assign o_col = r_col;

endmodule

// File: rtl/pp_column_shift_loader.sv
// Serial-to-column loader for an N x N partial-product compressor tree.
// Framed mode collects N beats then holds the frame until accepted;
// window mode shifts freely and flags validity once N beats have arrived.
module pp_column_shift_loader
    import pp_cols_pkg::*;
#(
    parameter int unsigned N      = 12,
    parameter bit          FRAMED = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*N-2:0]           in_bits,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N*N-1:0]           col_flat,
    output logic [$clog2(N+1)-1:0]   fill_cnt,
    output logic                     overflow_drop
);

    localparam int unsigned C     = 2 * N - 1;
    localparam int unsigned TOTAL = total_bits(N);
    localparam int unsigned CW    = $clog2(N + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_fill_cnt;
    logic [CW-1:0]   w_fill_nxt;
    logic            r_ovf;
    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_accept;
    logic            w_last_beat;
    logic            w_handshake;
    logic [TOTAL-1:0] w_col_flat;

    assign w_accept    = in_valid & w_in_ready & ~flush;
    assign w_last_beat = w_accept & (r_fill_cnt == CW'(N - 1));
    assign w_handshake = FRAMED & (r_state == HOLD) & out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; in window mode HOLD just means "window full" and only
    // flush or reset leaves it.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = FILL;
        end else begin
            case (r_state)
                FILL:    if (w_last_beat) w_state_nxt = HOLD;
                HOLD:    if (w_handshake) w_state_nxt = FILL;
                default: w_state_nxt = FILL;
            endcase
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        w_in_ready  = FRAMED ? (r_state == FILL) : 1'b1;
        w_out_valid = (r_state == HOLD);
    end

    // Beat counter: counts to N, cleared by flush or the output handshake,
    // saturating at N in window mode.
    always_comb begin
        w_fill_nxt = r_fill_cnt;
        if (flush) begin
            w_fill_nxt = '0;
        end else if (w_accept && (r_fill_cnt != CW'(N))) begin
            w_fill_nxt = r_fill_cnt + CW'(1);
        end else if (w_handshake) begin
            w_fill_nxt = '0;
        end
    end

    // Counter and drop-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_fill_cnt <= w_fill_nxt;
            r_ovf      <= FRAMED & in_valid & ~w_in_ready;
        end
    end

    generate
        for (genvar gi = 0; gi < C; gi++) begin : g_col
            localparam int unsigned H   = col_height(gi, N);
            localparam int unsigned OFF = col_offset(gi, N);
            pp_column_sreg #(
                .H (H)
            ) u_col (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_shift (w_accept),
                .i_clear (flush),
                .i_bit   (in_bits[gi]),
                .o_col   (w_col_flat[OFF+H-1:OFF])
            );
        end
    endgenerate

    assign in_ready      = w_in_ready;
    assign out_valid     = w_out_valid;
    assign col_flat      = w_col_flat;
    assign fill_cnt      = r_fill_cnt;
    assign overflow_drop = r_ovf;

endmodule

// File: tb/tb_pp_column_shift_loader.sv
// Directed bench for pp_column_shift_loader at N=4, framed and window modes.
module tb_pp_column_shift_loader;

    logic        clk;
    logic        rst_n;

    logic        f_in_valid, f_in_ready, f_flush, f_out_valid, f_out_ready, f_ovf;
    logic [6:0]  f_in_bits;
    logic [15:0] f_col;
    logic [2:0]  f_fill;

    logic        w_in_valid, w_in_ready, w_flush, w_out_valid, w_out_ready, w_ovf;
    logic [6:0]  w_in_bits;
    logic [15:0] w_col;
    logic [2:0]  w_fill;

    int n_vec;
    int n_miss;

    pp_column_shift_loader #(.N(4), .FRAMED(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n),
        .in_valid(f_in_valid), .in_ready(f_in_ready), .in_bits(f_in_bits),
        .flush(f_flush), .out_valid(f_out_valid), .out_ready(f_out_ready),
        .col_flat(f_col), .fill_cnt(f_fill), .overflow_drop(f_ovf)
    );

    pp_column_shift_loader #(.N(4), .FRAMED(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_bits(w_in_bits),
        .flush(w_flush), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .col_flat(w_col), .fill_cnt(w_fill), .overflow_drop(w_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic f_beat(input logic [6:0] b);
        f_in_valid = 1'b1;
        f_in_bits  = b;
        tick();
        f_in_valid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_f_col"},   32'(f_col),       32'h0);
        chk({tag, "_f_ov"},    32'(f_out_valid), 32'h0);
        chk({tag, "_f_ir"},    32'(f_in_ready),  32'h1);
        chk({tag, "_f_fill"},  32'(f_fill),      32'h0);
        chk({tag, "_f_drop"},  32'(f_ovf),       32'h0);
        chk({tag, "_w_col"},   32'(w_col),       32'h0);
        chk({tag, "_w_fill"},  32'(w_fill),      32'h0);
        chk({tag, "_w_ov"},    32'(w_out_valid), 32'h0);
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        rst_n = 1'b1;
        f_in_valid = 1'b0; f_in_bits = '0; f_flush = 1'b0; f_out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_bits = '0; w_flush = 1'b0; w_out_ready = 1'b0;

        // 1. asynchronous reset seen between edges
        #2 rst_n = 1'b0;
        #1 chk_reset("rst");
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // 2. framed fill with alternating beats
        f_beat(7'h7F);
        f_beat(7'h00);
        f_beat(7'h7F);
        chk("t2_fill3", 32'(f_fill), 32'd3);
        chk("t2_ov3",   32'(f_out_valid), 32'h0);
        f_beat(7'h00);
        chk("t2_ov",    32'(f_out_valid), 32'h1);
        chk("t2_col",   32'(f_col), 32'h4A94);
        chk("t2_col3",  32'(f_col[9:6]), 32'b1010);
        chk("t2_fill",  32'(f_fill), 32'd4);
        chk("t2_ir",    32'(f_in_ready), 32'h0);

        // 3. frame held under backpressure while beats keep arriving
        f_in_valid = 1'b1;
        f_in_bits  = 7'h55;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_col",  32'(f_col), 32'h4A94);
            chk("t3_ir",   32'(f_in_ready), 32'h0);
            chk("t3_fill", 32'(f_fill), 32'd4);
            chk("t3_drop", 32'(f_ovf), 32'h1);
            chk("t3_ov",   32'(f_out_valid), 32'h1);
        end
        // handshake with a beat still presented: frame released, beat dropped
        f_out_ready = 1'b1;
        tick();
        f_out_ready = 1'b0;
        f_in_valid  = 1'b0;
        chk("t3_hs_ov",   32'(f_out_valid), 32'h0);
        chk("t3_hs_fill", 32'(f_fill), 32'd0);
        chk("t3_hs_ir",   32'(f_in_ready), 32'h1);
        chk("t3_hs_drop", 32'(f_ovf), 32'h1);
        tick();
        chk("t3_drop_end", 32'(f_ovf), 32'h0);
        chk("t3_fill_end", 32'(f_fill), 32'd0);

        // 4. flush mid-frame with a beat presented in the same cycle
        f_beat(7'h7F);
        f_beat(7'h7F);
        chk("t4_fill2", 32'(f_fill), 32'd2);
        f_in_valid = 1'b1;
        f_in_bits  = 7'h7F;
        f_flush    = 1'b1;
        tick();
        f_flush    = 1'b0;
        f_in_valid = 1'b0;
        chk("t4_fl_fill", 32'(f_fill), 32'd0);
        chk("t4_fl_col",  32'(f_col), 32'h0);
        chk("t4_fl_ov",   32'(f_out_valid), 32'h0);
        f_beat(7'h0F);
        f_beat(7'h33);
        f_beat(7'h55);
        chk("t4_ov3",   32'(f_out_valid), 32'h0);
        chk("t4_fill3", 32'(f_fill), 32'd3);
        f_beat(7'h78);
        chk("t4_ov",    32'(f_out_valid), 32'h1);
        chk("t4_col",   32'(f_col), 32'hBE50);
        f_out_ready = 1'b1;
        tick();
        f_out_ready = 1'b0;
        chk("t4_rel", 32'(f_out_valid), 32'h0);

        // 5. window mode, six alternating beats
        for (int k = 1; k <= 6; k++) begin
            w_in_valid = 1'b1;
            w_in_bits  = (k % 2 == 1) ? 7'h7F : 7'h00;
            tick();
            chk("t5_ir",   32'(w_in_ready), 32'h1);
            chk("t5_drop", 32'(w_ovf), 32'h0);
            chk("t5_ov",   32'(w_out_valid), (k >= 4) ? 32'h1 : 32'h0);
            chk("t5_fill", 32'(w_fill), (k >= 4) ? 32'd4 : 32'(k));
        end
        w_in_valid = 1'b0;
        chk("t5_col",  32'(w_col), 32'h4A94);
        chk("t5_col3", 32'(w_col[9:6]), 32'b1010);
        tick();
        chk("t5_ov_hold", 32'(w_out_valid), 32'h1);

        // 6. asynchronous reset mid-frame, then a clean frame
        f_beat(7'h7F);
        f_beat(7'h7F);
        f_beat(7'h7F);
        chk("t6_fill3", 32'(f_fill), 32'd3);
        #2 rst_n = 1'b0;
        #1 chk_reset("t6_rst");
        tick();
        #2 rst_n = 1'b1;
        tick();
        f_beat(7'h7F);
        f_beat(7'h7F);
        f_beat(7'h00);
        f_beat(7'h7F);
        chk("t6_ov",  32'(f_out_valid), 32'h1);
        chk("t6_col", 32'(f_col), 32'hB76B);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
